// File: rtl/rv_pkg.sv
// Shared definitions for the write-back stage: datapath width, load encodings,
// WB state encoding and the holding-register control fields.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_HOLD  = 2'd1,
        WB_WAIT  = 2'd2
    } wb_state_e;

    // Data payload is held separately because its width follows the XLEN parameter.
    typedef struct packed {
        logic       is_load;
        logic [2:0] funct3;
        logic [2:0] addr_lo;
        logic       rf_wen;
        logic [4:0] waddr;
    } wb_req_t;

endpackage

// File: rtl/rv_load_ext.sv
// Load data aligner: picks byte/half/word at the address offset and sign/zero-extends.
// Purely combinational, no backpressure.
module rv_load_ext #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);
    import rv_pkg::*;

    logic [2:0]      off;
    logic [XLEN-1:0] sh;

    // A 32-bit datapath only has four byte lanes, so the top offset bit is dropped.
    assign off = addr_lo_i & ((XLEN == 64) ? 3'b111 : 3'b011);
    assign sh  = rdata_i >> {off, 3'b000};

    always_comb begin
        data_o = rdata_i;
        unique case (funct3_i)
            F3_LB:   data_o = XLEN'($signed(sh[7:0]));
            F3_LH:   data_o = XLEN'($signed(sh[15:0]));
            F3_LW:   data_o = XLEN'($signed(sh[31:0]));
            F3_LBU:  data_o = XLEN'(sh[7:0]);
            F3_LHU:  data_o = XLEN'(sh[15:0]);
            F3_LWU:  data_o = (XLEN == 64) ? XLEN'(sh[31:0]) : rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/rv_stage_wb_lsx.sv
// Write-back stage: holds one MEM result, waits for dmem on loads, commits to RF/forwarding.
// Non-loads commit the cycle after capture; loads on first rvalid; capture overlaps commit.
module rv_stage_wb_lsx #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mem_valid,
    output logic             o_mem_ready,
    input  logic             i_mem_is_load,
    input  logic [2:0]       i_mem_funct3,
    input  logic [2:0]       i_mem_addr_lo,
    input  logic             i_mem_rf_wen,
    input  logic [4:0]       i_mem_rf_waddr,
    input  logic [XLEN-1:0]  i_mem_rf_wdata_pre,
    input  logic             i_dmem_rvalid,
    input  logic [XLEN-1:0]  i_dmem_rdata,
    output logic             o_wb_rf_wen,
    output logic [4:0]       o_wb_rf_waddr,
    output logic [XLEN-1:0]  o_wb_rf_wdata,
    output logic             o_wb_fwd_valid,
    output logic [4:0]       o_wb_fwd_waddr,
    output logic [XLEN-1:0]  o_wb_fwd_data,
    output logic             o_wb_load_pending,
    output logic [4:0]       o_wb_pending_waddr,
    output logic [CNT_W-1:0] o_wb_retire_cnt,
    output logic             o_wb_err
);
    import rv_pkg::*;

    wb_state_e        state_q, state_d;
    wb_req_t          req_q, req_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             commit;
    logic             accept;
    logic [XLEN-1:0]  ld_data;

    rv_load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata_i   (i_dmem_rdata),
        .funct3_i  (req_q.funct3),
        .addr_lo_i (req_q.addr_lo),
        .data_o    (ld_data)
    );

    assign commit      = (state_q == WB_HOLD) | ((state_q == WB_WAIT) & i_dmem_rvalid);
    assign o_mem_ready = (state_q == WB_EMPTY) | commit;
    assign accept      = i_mem_valid & o_mem_ready;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wdata_d = wdata_q;
        if (accept) begin
            req_d.is_load = i_mem_is_load;
            req_d.funct3  = i_mem_funct3;
            req_d.addr_lo = i_mem_addr_lo;
            req_d.rf_wen  = i_mem_rf_wen;
            req_d.waddr   = i_mem_rf_waddr;
            wdata_d       = i_mem_rf_wdata_pre;
            state_d       = i_mem_is_load ? WB_WAIT : WB_HOLD;
        end else if (commit) begin
            state_d = WB_EMPTY;
        end
    end

    assign cnt_d = commit ? cnt_q + CNT_W'(1) : cnt_q;
    // A response is only legitimate while a load sits in WAIT; anything else is sticky.
    assign err_d = err_q | (i_dmem_rvalid & (state_q != WB_WAIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WB_EMPTY;
            req_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_wb_rf_wen        = commit & req_q.rf_wen & (req_q.waddr != 5'd0);
    assign o_wb_rf_waddr      = req_q.waddr;
    assign o_wb_rf_wdata      = req_q.is_load ? ld_data : wdata_q;
    assign o_wb_fwd_valid     = o_wb_rf_wen;
    assign o_wb_fwd_waddr     = o_wb_rf_waddr;
    assign o_wb_fwd_data      = o_wb_rf_wdata;
    assign o_wb_load_pending  = (state_q == WB_WAIT) & ~i_dmem_rvalid;
    assign o_wb_pending_waddr = o_wb_load_pending ? req_q.waddr : 5'd0;
    assign o_wb_retire_cnt    = cnt_q;
    assign o_wb_err           = err_q;

endmodule

// File: tb/tb_rv_stage_wb_lsx.sv
// Directed bench for rv_stage_wb_lsx: a 32-bit/64-bit-counter instance and a
// 64-bit/4-bit-counter instance driven from one linear sequence.
module tb_rv_stage_wb_lsx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Instance A: XLEN=32, CNT_W=64
    logic        a_mem_valid, a_mem_ready, a_is_load, a_wen_in, a_rvalid;
    logic [2:0]  a_f3, a_addr;
    logic [4:0]  a_waddr_in;
    logic [31:0] a_wdata_in, a_rdata;
    logic        a_rf_wen, a_fwd_valid, a_pend, a_err;
    logic [4:0]  a_rf_waddr, a_fwd_waddr, a_pend_waddr;
    logic [31:0] a_rf_wdata, a_fwd_data;
    logic [63:0] a_cnt;

    // Instance B: XLEN=64, CNT_W=4
    logic        b_mem_valid, b_mem_ready, b_is_load, b_wen_in, b_rvalid;
    logic [2:0]  b_f3, b_addr;
    logic [4:0]  b_waddr_in;
    logic [63:0] b_wdata_in, b_rdata;
    logic        b_rf_wen, b_fwd_valid, b_pend, b_err;
    logic [4:0]  b_rf_waddr, b_fwd_waddr, b_pend_waddr;
    logic [63:0] b_rf_wdata, b_fwd_data;
    logic [3:0]  b_cnt;

    rv_stage_wb_lsx #(.XLEN(32), .CNT_W(64)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mem_valid(a_mem_valid), .o_mem_ready(a_mem_ready),
        .i_mem_is_load(a_is_load), .i_mem_funct3(a_f3), .i_mem_addr_lo(a_addr),
        .i_mem_rf_wen(a_wen_in), .i_mem_rf_waddr(a_waddr_in), .i_mem_rf_wdata_pre(a_wdata_in),
        .i_dmem_rvalid(a_rvalid), .i_dmem_rdata(a_rdata),
        .o_wb_rf_wen(a_rf_wen), .o_wb_rf_waddr(a_rf_waddr), .o_wb_rf_wdata(a_rf_wdata),
        .o_wb_fwd_valid(a_fwd_valid), .o_wb_fwd_waddr(a_fwd_waddr), .o_wb_fwd_data(a_fwd_data),
        .o_wb_load_pending(a_pend), .o_wb_pending_waddr(a_pend_waddr),
        .o_wb_retire_cnt(a_cnt), .o_wb_err(a_err)
    );

    rv_stage_wb_lsx #(.XLEN(64), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mem_valid(b_mem_valid), .o_mem_ready(b_mem_ready),
        .i_mem_is_load(b_is_load), .i_mem_funct3(b_f3), .i_mem_addr_lo(b_addr),
        .i_mem_rf_wen(b_wen_in), .i_mem_rf_waddr(b_waddr_in), .i_mem_rf_wdata_pre(b_wdata_in),
        .i_dmem_rvalid(b_rvalid), .i_dmem_rdata(b_rdata),
        .o_wb_rf_wen(b_rf_wen), .o_wb_rf_waddr(b_rf_waddr), .o_wb_rf_wdata(b_rf_wdata),
        .o_wb_fwd_valid(b_fwd_valid), .o_wb_fwd_waddr(b_fwd_waddr), .o_wb_fwd_data(b_fwd_data),
        .o_wb_load_pending(b_pend), .o_wb_pending_waddr(b_pend_waddr),
        .o_wb_retire_cnt(b_cnt), .o_wb_err(b_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load on A with the response in the cycle right after capture.
    task automatic load_a(input logic [2:0] f3, input logic [2:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp, input string tag);
        a_mem_valid = 1'b1; a_is_load = 1'b1; a_f3 = f3; a_addr = addr;
        a_wen_in = 1'b1; a_waddr_in = rd;
        tick();
        a_mem_valid = 1'b0; a_is_load = 1'b0;
        #1 chk({tag, "_pend"}, 64'(a_pend), 64'd1);
        a_rvalid = 1'b1; a_rdata = rdata;
        #1 chk({tag, "_data"}, 64'(a_rf_wdata), 64'(exp));
        chk({tag, "_wen"}, 64'(a_rf_wen), 64'd1);
        tick();
        a_rvalid = 1'b0;
    endtask

    task automatic load_b(input logic [2:0] f3, input logic [2:0] addr, input logic [4:0] rd,
                          input logic [63:0] rdata, input logic [63:0] exp, input string tag);
        b_mem_valid = 1'b1; b_is_load = 1'b1; b_f3 = f3; b_addr = addr;
        b_wen_in = 1'b1; b_waddr_in = rd;
        tick();
        b_mem_valid = 1'b0; b_is_load = 1'b0;
        b_rvalid = 1'b1; b_rdata = rdata;
        #1 chk({tag, "_data"}, b_rf_wdata, exp);
        tick();
        b_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_mem_valid = 0; a_is_load = 0; a_wen_in = 0; a_rvalid = 0;
        a_f3 = 0; a_addr = 0; a_waddr_in = 0; a_wdata_in = 0; a_rdata = 0;
        b_mem_valid = 0; b_is_load = 0; b_wen_in = 0; b_rvalid = 0;
        b_f3 = 0; b_addr = 0; b_waddr_in = 0; b_wdata_in = 0; b_rdata = 0;

        // Reset values
        #2;
        chk("rst_ready", 64'(a_mem_ready), 64'd1);
        chk("rst_wen", 64'(a_rf_wen), 64'd0);
        chk("rst_wdata", 64'(a_rf_wdata), 64'd0);
        chk("rst_pend", 64'(a_pend), 64'd0);
        chk("rst_cnt", a_cnt, 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        #5 rst_n = 1'b1;
        tick();

        // ALU op x5 = 0x1234
        a_mem_valid = 1; a_wen_in = 1; a_waddr_in = 5'd5; a_wdata_in = 32'h1234;
        tick();
        a_mem_valid = 0;
        #1;
        chk("alu_wen", 64'(a_rf_wen), 64'd1);
        chk("alu_waddr", 64'(a_rf_waddr), 64'd5);
        chk("alu_wdata", 64'(a_rf_wdata), 64'h1234);
        chk("alu_fwd_valid", 64'(a_fwd_valid), 64'd1);
        chk("alu_fwd_data", 64'(a_fwd_data), 64'h1234);
        tick();
        chk("alu_cnt", a_cnt, 64'd1);
        chk("alu_idle_wen", 64'(a_rf_wen), 64'd0);

        // LB x7, offset 2, response three cycles after capture
        a_mem_valid = 1; a_is_load = 1; a_f3 = 3'b000; a_addr = 3'd2; a_wen_in = 1; a_waddr_in = 5'd7;
        tick();
        a_mem_valid = 0; a_is_load = 0;
        chk("lb_pend1", 64'(a_pend), 64'd1);
        chk("lb_pwaddr1", 64'(a_pend_waddr), 64'd7);
        chk("lb_ready_wait", 64'(a_mem_ready), 64'd0);
        chk("lb_wen_wait", 64'(a_rf_wen), 64'd0);
        tick();
        chk("lb_pend2", 64'(a_pend), 64'd1);
        chk("lb_pwaddr2", 64'(a_pend_waddr), 64'd7);
        tick();
        a_rvalid = 1; a_rdata = 32'h1180_2233;
        #1;
        chk("lb_data", 64'(a_rf_wdata), 64'hFFFF_FF80);
        chk("lb_wen", 64'(a_rf_wen), 64'd1);
        chk("lb_pend_done", 64'(a_pend), 64'd0);
        chk("lb_pwaddr_done", 64'(a_pend_waddr), 64'd0);
        tick();
        a_rvalid = 0;
        chk("lb_cnt", a_cnt, 64'd2);

        load_a(3'b100, 3'd2, 5'd8, 32'h1180_2233, 32'h0000_0080, "lbu");
        load_a(3'b001, 3'd2, 5'd9, 32'h8001_0000, 32'hFFFF_8001, "lh");
        load_a(3'b101, 3'd2, 5'd9, 32'h8001_0000, 32'h0000_8001, "lhu");
        load_a(3'b010, 3'd0, 5'd9, 32'h8001_0000, 32'h8001_0000, "lw");
        load_a(3'b000, 3'd7, 5'd9, 32'h8800_0000, 32'hFFFF_FF88, "lb_off7_wraps");
        chk("loads_cnt", a_cnt, 64'd7);

        // Back-to-back ALU ops, op 4 targets x0
        do_reset();
        a_is_load = 0; a_wen_in = 1;
        for (int i = 0; i < 10; i++) begin
            a_mem_valid = 1;
            a_waddr_in  = (i == 4) ? 5'd0 : 5'(i + 1);
            a_wdata_in  = 32'(i * 16);
            #1;
            chk($sformatf("b2b_ready%0d", i), 64'(a_mem_ready), 64'd1);
            if (i > 0) begin
                chk($sformatf("b2b_wen%0d", i - 1), 64'(a_rf_wen), (i - 1 == 4) ? 64'd0 : 64'd1);
                chk($sformatf("b2b_wdata%0d", i - 1), 64'(a_rf_wdata), 64'((i - 1) * 16));
            end
            tick();
        end
        a_mem_valid = 0;
        #1;
        chk("b2b_wen9", 64'(a_rf_wen), 64'd1);
        chk("b2b_wdata9", 64'(a_rf_wdata), 64'h90);
        tick();
        chk("b2b_cnt", a_cnt, 64'd10);

        // Stray response while EMPTY, then reset in the middle of a WAIT
        a_rvalid = 1; a_rdata = 32'hDEAD_BEEF;
        tick();
        a_rvalid = 0;
        chk("err_set", 64'(a_err), 64'd1);
        tick();
        chk("err_sticky", 64'(a_err), 64'd1);
        a_mem_valid = 1; a_is_load = 1; a_f3 = 3'b010; a_addr = 0; a_waddr_in = 5'd3;
        tick();
        a_mem_valid = 0; a_is_load = 0;
        chk("wait_pend", 64'(a_pend), 64'd1);
        rst_n = 0;
        #1;
        chk("midrst_err", 64'(a_err), 64'd0);
        chk("midrst_cnt", a_cnt, 64'd0);
        chk("midrst_pend", 64'(a_pend), 64'd0);
        chk("midrst_ready", 64'(a_mem_ready), 64'd1);
        #1 rst_n = 1;
        a_rvalid = 1;
        #1 chk("late_rsp_wen", 64'(a_rf_wen), 64'd0);
        tick();
        a_rvalid = 0;
        chk("late_rsp_err", 64'(a_err), 64'd1);
        chk("late_rsp_cnt", a_cnt, 64'd0);

        // XLEN=64 instance
        do_reset();
        load_b(3'b110, 3'd4, 5'd4, 64'hFEDC_BA98_0000_0000, 64'h0000_0000_FEDC_BA98, "b_lwu");
        load_b(3'b010, 3'd4, 5'd4, 64'hFEDC_BA98_0000_0000, 64'hFFFF_FFFF_FEDC_BA98, "b_lw");
        load_b(3'b011, 3'd0, 5'd4, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, "b_ld");
        load_b(3'b001, 3'd6, 5'd4, 64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_8123, "b_lh6");
        b_is_load = 0; b_wen_in = 1; b_waddr_in = 5'd1;
        for (int i = 0; i < 13; i++) begin
            b_mem_valid = 1;
            b_wdata_in  = 64'(i);
            tick();
        end
        b_mem_valid = 0;
        tick();
        chk("b_cnt_wrap", 64'(b_cnt), 64'd1);
        chk("b_err", 64'(b_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rv_stage_wb_lsx.md
Name: rv_stage_wb_lsx

Overview:
Parametrised write-back stage for variable-latency data memory. Captures MEM-stage results into a WB holding register under a valid/ready handshake. For loads, waits for the dmem read response, then aligns and sign- or zero-extends byte/half/word(/double) data. Commits to the register file, drives the forwarding bus, and reports a pending-load hazard to ID/EX. Keeps a retired-instruction counter and a sticky protocol-error flag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
CNT_W, 64, width of the retire counter; range 1..64.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_mem_valid  in  1  MEM presents an instruction
o_mem_ready  out  1  WB can accept this cycle
i_mem_is_load  in  1  instruction is a load
i_mem_funct3  in  3  load size/sign (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
i_mem_addr_lo  in  3  low bits of the load address (byte offset within the XLEN word)
i_mem_rf_wen  in  1  instruction writes rd
i_mem_rf_waddr  in  5  rd
i_mem_rf_wdata_pre  in  XLEN  ALU/CSR/link result
i_dmem_rvalid  in  1  dmem read response valid
i_dmem_rdata  in  XLEN  raw dmem word
o_wb_rf_wen  out  1  register-file write enable
o_wb_rf_waddr  out  5  register-file write address
o_wb_rf_wdata  out  XLEN  register-file write data
o_wb_fwd_valid  out  1  forwarding data valid (equal to o_wb_rf_wen)
o_wb_fwd_waddr  out  5  forwarded rd
o_wb_fwd_data  out  XLEN  forwarded value
o_wb_load_pending  out  1  load occupying WB, response not yet received
o_wb_pending_waddr  out  5  rd of the pending load (0 if none)
o_wb_retire_cnt  out  CNT_W  committed-instruction count
o_wb_err  out  1  sticky: i_dmem_rvalid arrived with no load waiting

Behaviour:
- Reset (async assert, sync release) clears all state: occupied=0, state EMPTY, counter=0, err=0.
- Reset values of outputs: every output is 0 except o_mem_ready, which is 1.
- Holding register fields: is_load, funct3, addr_lo, rf_wen, waddr, wdata_pre.
- States:
  - EMPTY: nothing held.
  - HOLD: non-load held.
  - WAIT: load held, no response yet.
- commit = (state==HOLD) | (state==WAIT & i_dmem_rvalid). Commit is combinational in the same cycle.
- o_mem_ready = (state==EMPTY) | commit. This is a pipelined accept: capture and commit can happen in the same cycle.
- Accept = i_mem_valid & o_mem_ready. On accept, load the holding register. Next state is WAIT if is_load, else HOLD. No accept after a commit → EMPTY. No commit → state holds.
- Latency:
  - Non-load: captured at edge N, committed during cycle N+1.
  - Load: committed in the first cycle i_dmem_rvalid=1 while in WAIT.
  - An rvalid in the same cycle as the load's capture belongs to the previous occupant or is an error. It is never used for the new load.
- Load extraction: shift = addr_lo × 8.
  - XLEN=32 uses addr_lo[1:0]; addr_lo[2] is ignored.
  - Byte = rdata[shift+:8]; half = rdata[shift+:16]; word = rdata[shift+:32].
  - Signed forms sign-extend to XLEN; U forms zero-extend.
  - LD, and LWU/LD when XLEN=32: pass the word through unchanged.
  - Misaligned offsets are not checked; the slice is still computed within XLEN.
- o_wb_rf_wen = commit & rf_wen & (waddr≠0). Writes to x0 are suppressed.
- o_wb_rf_wdata = is_load ? extracted : wdata_pre.
- Fwd outputs mirror the rf outputs in the same cycle.
- o_wb_load_pending = (state==WAIT) & ~i_dmem_rvalid.
- o_wb_pending_waddr = waddr when o_wb_load_pending is 1, else 0.
- Retire counter increments by 1 on every commit, including x0 writes and rf_wen=0. It wraps modulo 2^CNT_W.
- o_wb_err is set when i_dmem_rvalid=1 and state≠WAIT. It is cleared only by reset.
- Reset mid-WAIT discards the held load. A response arriving after reset release sets err.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN
  - funct3 load encodings (F3_LB … F3_LWU)
  - typedef wb_state_e {WB_EMPTY, WB_HOLD, WB_WAIT}
  - packed struct wb_req_t for the holding-register fields
- One combinational sub-module, rv_load_ext: inputs rdata, funct3, addr_lo; output is the extended XLEN value.

Test Plan:
- ALU op x5=0x1234 accepted at cycle 1 → rf_wen=1, waddr=5, wdata=0x00001234 at cycle 2; retire_cnt=1.
- LB, addr_lo=2, rdata=0x11_80_22_33, rvalid three cycles after capture:
  - load_pending=1 and pending_waddr=rd for 2 cycles;
  - then wdata=0xFFFFFF80;
  - the same response with LBU gives 0x00000080.
- LH, addr_lo=2, rdata=0x8001_0000 → 0xFFFF8001; LHU → 0x00008001; LW → rdata unchanged.
- Back-to-back ALU ops with i_mem_valid held high:
  - o_mem_ready stays 1;
  - one commit per cycle;
  - 10 ops → retire_cnt=10;
  - an op with rd=x0 → rf_wen=0 but the counter still increments.
- Stray rvalid while EMPTY → o_wb_err=1 and stays 1; an assert of i_rst_n=0 in the middle of a WAIT clears err, the counter, and pending with no rf write.
- XLEN=64: LWU, addr_lo=4, rdata=0xFEDCBA98_00000000 → 0x00000000FEDCBA98; LW → 0xFFFFFFFFFEDCBA98.
- XLEN=64, CNT_W=4: 17 commits → counter=1.
